// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative radix-2 divider.
//   DIV_OP_*    : request opcode encodings seen on req_op_i.
//   divState_e  : controller states (IDLE, CALC, FIXUP).
//   magnitude() : conditional two's-complement negate. It forms |x| at
//                 accept and re-applies the sign at fixup.
package div_iter_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } divState_e;

  // Negating the most-negative value returns that value. Read as unsigned,
  // this is the correct magnitude, so overflow needs no special case.
  function automatic logic [63:0] magnitude(input logic [63:0] value,
                                            input logic        negate);
    return negate ? (~value + 64'd1) : value;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step. The module is purely combinational.
//   i_rem     : partial remainder (always below the divisor)
//   i_inBit   : next dividend bit shifted in at the bottom
//   i_divisor : divisor magnitude
//   o_rem     : updated partial remainder
//   o_qBit    : quotient bit produced by this step
module div_iter_step (
  input  logic [63:0] i_rem,
  input  logic        i_inBit,
  input  logic [63:0] i_divisor,
  output logic [63:0] o_rem,
  output logic        o_qBit
);

  logic [64:0] w_shifted;
  logic [64:0] w_diff;

  // The shifted remainder can reach 65 bits. Its difference with the
  // divisor fits in 65-bit two's complement, so bit 64 is a reliable sign.
  // When the subtraction is rejected, the shifted value is below the
  // divisor, so its low 64 bits hold the whole value.
  assign w_shifted = {i_rem, i_inBit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_qBit    = ~w_diff[64];
  assign o_rem     = o_qBit ? w_diff[63:0] : w_shifted[63:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 integer divider for RV64M DIV/DIVU/REM/REMU and the W
// variants. It produces one quotient bit per cycle, and divide-by-zero
// skips the iteration.
//   clk_i, rst_ni               : clock, synchronous active-high reset
//   operand_a_i, operand_b_i    : dividend, divisor
//   req_op_i, req_word_i        : opcode (DIV_OP_*), 32-bit W variant
//   req_valid_i / req_ready_o   : request handshake; ready while IDLE
//   flush_i                     : abort the in-flight operation
//   resp_valid_o, resp_value_o  : one-cycle result pulse; the value is held
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [1:0]      req_op_i,
  input  logic            req_word_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            flush_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_value_o
);

  divState_e   r_state, w_nextState;
  logic [63:0] r_quo, r_rem, r_div, r_respValue;
  logic [5:0]  r_cnt;
  logic        r_negQ, r_negR, r_isRem, r_word, r_divZero, r_respValid;

  logic        w_signed, w_isRem, w_accept, w_divZero, w_validD;
  logic        w_aNeg, w_bNeg, w_stepQ, w_resNeg;
  logic [63:0] w_aExt, w_bExt, w_aMag, w_bMag, w_stepRem;
  logic [63:0] w_resMag, w_resSigned, w_preResult, w_result;

  // A flush in IDLE blocks the accept, so a flushed request is never latched.
  assign w_accept  = req_valid_i && (r_state == IDLE) && !flush_i;
  assign w_signed  = (req_op_i == DIV_OP_DIV) || (req_op_i == DIV_OP_REM);
  assign w_isRem   = (req_op_i == DIV_OP_REM) || (req_op_i == DIV_OP_REMU);

  // Operand conditioning at accept. Word ops use only the low halves,
  // extended according to signedness, so the remaining logic is uniform.
  always_comb begin
    w_aExt = operand_a_i;
    w_bExt = operand_b_i;
    if (req_word_i) begin
      w_aExt = {{32{w_signed & operand_a_i[31]}}, operand_a_i[31:0]};
      w_bExt = {{32{w_signed & operand_b_i[31]}}, operand_b_i[31:0]};
    end
  end

  assign w_aNeg    = w_signed & w_aExt[63];
  assign w_bNeg    = w_signed & w_bExt[63];
  assign w_aMag    = magnitude(w_aExt, w_aNeg);
  assign w_bMag    = magnitude(w_bExt, w_bNeg);
  assign w_divZero = (w_bExt == 64'd0);

  // The dividend shifts out of the top of r_quo while quotient bits enter
  // at the bottom.
  div_iter_step u_step (
    .i_rem     (r_rem),
    .i_inBit   (r_quo[63]),
    .i_divisor (r_div),
    .o_rem     (w_stepRem),
    .o_qBit    (w_stepQ)
  );

  // Controller state register.
  always_ff @(posedge clk_i) begin
    if (rst_ni) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic. The result pulse request (w_validD) is raised only
  // in FIXUP, and a flush in that cycle cancels it.
  always_comb begin
    w_nextState = r_state;
    w_validD    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = w_divZero ? FIXUP : CALC;
      end
      CALC: begin
        if (flush_i)             w_nextState = IDLE;
        else if (r_cnt == 6'd0)  w_nextState = FIXUP;
      end
      FIXUP: begin
        w_nextState = IDLE;
        w_validD    = !flush_i;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result formation. Signs are re-applied to the magnitudes. A zero
  // divisor forces the quotient to all ones. The remainder path already
  // holds |a|, so it yields the dividend. Word ops sign-extend bit 31.
  assign w_resMag    = r_isRem ? r_rem  : r_quo;
  assign w_resNeg    = r_isRem ? r_negR : r_negQ;
  assign w_resSigned = magnitude(w_resMag, w_resNeg);

  always_comb begin
    w_preResult = w_resSigned;
    if (r_divZero && !r_isRem) w_preResult = '1;
    w_result = w_preResult;
    if (r_word) w_result = {{32{w_preResult[31]}}, w_preResult[31:0]};
  end

  // Datapath registers. These latch at accept and step once per CALC
  // cycle. For word ops, the 32-bit dividend is placed at the top of
  // r_quo, so 32 steps consume it and leave the quotient in the low half.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_negQ      <= 1'b0;
      r_negR      <= 1'b0;
      r_isRem     <= 1'b0;
      r_word      <= 1'b0;
      r_divZero   <= 1'b0;
      r_respValid <= 1'b0;
      r_respValue <= '0;
    end else begin
      r_respValid <= w_validD;
      if (w_validD) r_respValue <= w_result;
      if (w_accept) begin
        r_quo     <= req_word_i ? {w_aMag[31:0], 32'd0} : w_aMag;
        r_rem     <= w_divZero ? w_aMag : 64'd0;
        r_div     <= w_bMag;
        r_cnt     <= req_word_i ? 6'd31 : 6'd63;
        r_negQ    <= w_aNeg ^ w_bNeg;
        r_negR    <= w_aNeg;
        r_isRem   <= w_isRem;
        r_word    <= req_word_i;
        r_divZero <= w_divZero;
      end else if (r_state == CALC) begin
        r_quo <= {r_quo[62:0], w_stepQ};
        r_rem <= w_stepRem;
        r_cnt <= r_cnt - 6'd1;
      end
    end
  end

  assign req_ready_o  = (r_state == IDLE);
  assign resp_valid_o = r_respValid;
  assign resp_value_o = r_respValue;

endmodule
